// File: rtl/gate_activation.sv
// Bias-add plus piecewise-linear activation, one element per cycle.
// Ports: clk, reset (sync, active-high), dataReady, inVector, biasVector,
//   outVector, outValid (one-cycle done pulse), busy, overrun (sticky).
// Build option: define GATE_HARD_TANH_EN for hard tanh; default is hard sigmoid.
module gate_activation #(
    parameter int NROW            = 16,
    parameter int QN              = 6,
    parameter int QM              = 11,
    parameter int BITWIDTH        = QN + QM + 1,
    parameter int MEMORY_BITWIDTH = BITWIDTH * NROW,
    parameter int IDX_BITWIDTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dataReady,
    input  logic [MEMORY_BITWIDTH-1:0] inVector,
    input  logic [MEMORY_BITWIDTH-1:0] biasVector,
    output logic [MEMORY_BITWIDTH-1:0] outVector,
    output logic                       outValid,
    output logic                       busy,
    output logic                       overrun
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic signed [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic signed [BITWIDTH-1:0] ONE     = BITWIDTH'(2 ** QM);
    localparam logic [IDX_BITWIDTH-1:0]    LAST    = IDX_BITWIDTH'(NROW - 1);

    state_t                     state;
    logic [IDX_BITWIDTH-1:0]    idx;
    logic                       dr_prev;
    logic signed [BITWIDTH-1:0] in_buf   [NROW];
    logic signed [BITWIDTH-1:0] bias_lane[NROW];
    logic signed [BITWIDTH-1:0] out_lane [NROW];

    logic                       start;
    logic                       last;
    logic                       capture;
    logic [BITWIDTH:0]          sum_wide;
    logic signed [BITWIDTH-1:0] s_sat;
    logic signed [BITWIDTH-1:0] act;

    for (genvar k = 0; k < NROW; k++) begin : g_lane
        assign bias_lane[k] = biasVector[k*BITWIDTH +: BITWIDTH];
        assign outVector[k*BITWIDTH +: BITWIDTH] = out_lane[k];
    end

    assign start   = dataReady & ~dr_prev;
    assign last    = (state == RUN) && (idx == LAST);
    // A start on the final lane chains straight into the next run.
    assign capture = start && ((state == IDLE) || last);

`ifdef GATE_HARD_TANH_EN
    localparam logic signed [BITWIDTH-1:0] NEG_ONE = -ONE;

    always_comb begin
        act = s_sat;
        if (s_sat > ONE) begin
            act = ONE;
        end else if (s_sat < NEG_ONE) begin
            act = NEG_ONE;
        end
    end
`else
    localparam logic signed [BITWIDTH:0] HALF_W = (BITWIDTH+1)'(2 ** (QM - 1));
    localparam logic signed [BITWIDTH:0] ONE_W  = (BITWIDTH+1)'(ONE);

    logic signed [BITWIDTH-1:0] shifted;
    logic signed [BITWIDTH:0]   sig;

    always_comb begin
        shifted = s_sat >>> 2;
        sig     = {shifted[BITWIDTH-1], shifted} + HALF_W;
        act     = sig[BITWIDTH-1:0];
        if (sig[BITWIDTH]) begin
            act = '0;
        end else if (sig > ONE_W) begin
            act = ONE;
        end
    end
`endif

    // One extra bit for the sum; overflow shows as the top two bits differing.
    always_comb begin
        sum_wide = {in_buf[idx][BITWIDTH-1], in_buf[idx]}
                 + {bias_lane[idx][BITWIDTH-1], bias_lane[idx]};
        s_sat    = sum_wide[BITWIDTH-1:0];
        if (sum_wide[BITWIDTH] != sum_wide[BITWIDTH-1]) begin
            s_sat = sum_wide[BITWIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            dr_prev  <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            for (int k = 0; k < NROW; k++) begin
                in_buf[k]   <= '0;
                out_lane[k] <= '0;
            end
        end else begin
            dr_prev  <= dataReady;
            outValid <= 1'b0;
            if (capture) begin
                for (int k = 0; k < NROW; k++) begin
                    in_buf[k] <= inVector[k*BITWIDTH +: BITWIDTH];
                end
            end
            unique case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    busy          <= 1'b1;
                    out_lane[idx] <= act;
                    if (last) begin
                        outValid <= 1'b1;
                        idx      <= '0;
                        state    <= start ? RUN : IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                        if (start) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_activation.sv
// Scoreboard bench for gate_activation: directed vectors, queued expectations,
// negedge monitor compares each outValid against the queue head.
module tb_gate_activation;

    localparam int N  = 16;
    localparam int BW = 18;
    localparam int MW = BW * N;
`ifdef GATE_HARD_TANH_EN
    localparam bit TANH = 1'b1;
`else
    localparam bit TANH = 1'b0;
`endif

    typedef struct {
        logic [MW-1:0] vec;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dataReady = 1'b0;
    logic [MW-1:0] inVector = '0;
    logic [MW-1:0] biasVector = '0;
    logic [MW-1:0] outVector;
    logic          outValid;
    logic          busy;
    logic          overrun;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sbq[$];

    logic [MW-1:0] iv1, ev1, iv2, ev2, iv3, bv3, ev3;

    gate_activation dut (
        .clk(clk),
        .reset(reset),
        .dataReady(dataReady),
        .inVector(inVector),
        .biasVector(biasVector),
        .outVector(outVector),
        .outValid(outValid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [MW-1:0] act,
                         input logic [MW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] put(input logic [MW-1:0] v,
                                          input int k, input int x);
        v[k*BW +: BW] = BW'(x);
        return v;
    endfunction

    function automatic logic [MW-1:0] fill(input int x);
        logic [MW-1:0] v = '0;
        for (int k = 0; k < N; k++) v = put(v, k, x);
        return v;
    endfunction

    // Call just after a negedge: start is sampled at the next posedge (t),
    // completion is visible at the negedge after edge t+16.
    task automatic launch(input logic [MW-1:0] iv, input logic [MW-1:0] ev,
                          input bit expect_done);
        exp_t e;
        inVector  = iv;
        dataReady = 1'b1;
        if (expect_done) begin
            e.vec = ev;
            e.cyc = cyc + 1 + N;
            sbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && outValid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_outValid: got 1 at cycle %0d expected 0", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_vector", outVector, e.vec);
                check("out_cycle", MW'(cyc), MW'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        iv1 = '0;
        ev1 = fill(TANH ? 0 : 1024);

        iv2 = put(put(put('0, 0, 8192), 1, -8192), 2, 400);
        ev2 = fill(TANH ? 0 : 1024);
        ev2 = put(ev2, 0, 2048);
        ev2 = put(ev2, 1, TANH ? -2048 : 0);
        ev2 = put(ev2, 2, TANH ? 400 : 1124);

        iv3 = '0;
        bv3 = '0;
        ev3 = fill(TANH ? 0 : 1024);
        iv3 = put(iv3, 0, 131071);   bv3 = put(bv3, 0, 131071);
        ev3 = put(ev3, 0, 2048);
        iv3 = put(iv3, 1, -131072);  bv3 = put(bv3, 1, -131072);
        ev3 = put(ev3, 1, TANH ? -2048 : 0);
        iv3 = put(iv3, 2, 4096);
        ev3 = put(ev3, 2, 2048);
        iv3 = put(iv3, 3, -4096);
        ev3 = put(ev3, 3, TANH ? -2048 : 0);
        iv3 = put(iv3, 4, -4100);
        ev3 = put(ev3, 4, TANH ? -2048 : 0);
        iv3 = put(iv3, 5, 1000);     bv3 = put(bv3, 5, -600);
        ev3 = put(ev3, 5, TANH ? 400 : 1124);
        iv3 = put(iv3, 6, 131071);   bv3 = put(bv3, 6, -131072);
        ev3 = put(ev3, 6, TANH ? -1 : 1023);
        iv3 = put(iv3, 7, 2047);
        ev3 = put(ev3, 7, TANH ? 2047 : 1535);
        iv3 = put(iv3, 8, 3000);     bv3 = put(bv3, 8, 1000);
        ev3 = put(ev3, 8, TANH ? 2048 : 2024);
        iv3 = put(iv3, 15, -1);
        ev3 = put(ev3, 15, TANH ? -1 : 1023);

        repeat (3) @(negedge clk);
        check("rst_outVector", outVector, '0);
        check("rst_outValid", MW'(outValid), '0);
        check("rst_busy", MW'(busy), '0);
        check("rst_overrun", MW'(overrun), '0);
        reset = 1'b0;

        // Single pulse, all zero inputs.
        @(negedge clk);
        launch(iv1, ev1, 1'b1);
        @(negedge clk);
        dataReady = 1'b0;
        check("busy_in_run", MW'(busy), MW'(1));
        repeat (20) @(negedge clk);
        check("busy_after_run", MW'(busy), '0);

        // dataReady held high for 16 cycles: one run only.
        launch(iv2, ev2, 1'b1);
        repeat (16) @(negedge clk);
        dataReady = 1'b0;
        repeat (10) @(negedge clk);
        check("overrun_held_high", MW'(overrun), '0);

        // Second rising edge at t+5 is ignored and flagged.
        launch(iv1, ev1, 1'b1);
        @(negedge clk);
        dataReady = 1'b0;
        repeat (4) @(negedge clk);
        dataReady = 1'b1;
        @(negedge clk);
        dataReady = 1'b0;
        check("overrun_set", MW'(overrun), MW'(1));
        repeat (20) @(negedge clk);
        check("overrun_sticky", MW'(overrun), MW'(1));

        // Back-to-back: second start on the lane-15 edge.
        launch(iv1, ev1, 1'b1);
        @(negedge clk);
        dataReady = 1'b0;
        repeat (15) @(negedge clk);
        launch(iv2, ev2, 1'b1);
        @(negedge clk);
        dataReady = 1'b0;
        check("b2b_busy_t16", MW'(busy), MW'(1));
        @(negedge clk);
        check("b2b_busy_t17", MW'(busy), MW'(1));
        repeat (20) @(negedge clk);

        // Reset at edge t+8 abandons the run.
        launch(iv2, ev2, 1'b0);
        @(negedge clk);
        dataReady = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_outVector", outVector, '0);
        check("midrst_busy", MW'(busy), '0);
        check("midrst_outValid", MW'(outValid), '0);
        check("midrst_overrun", MW'(overrun), '0);
        reset = 1'b0;
        repeat (25) @(negedge clk);

        // Saturation and clamp boundaries after the aborted run.
        biasVector = bv3;
        launch(iv3, ev3, 1'b1);
        @(negedge clk);
        dataReady = 1'b0;
        repeat (20) @(negedge clk);
        biasVector = '0;

        for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL missing_outValid: got %0d pending expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_activation.md
# gate_activation

Element-wise bias-add and piecewise-linear activation stage directly downstream of the weight/vector dot-product unit. It captures the full dot-product result vector when the producer signals `dataReady`, adds a per-row bias with saturation, applies a hard activation one element per cycle, and presents the finished gate vector with a single-cycle `outValid` pulse. It feeds the cell-state/hidden-state update logic of the recurrent layer.

## Interface
- `NROW`, 16, number of vector elements (rows of the dot-product output)
- `QN`, 6, integer bits of the fixed-point format
- `QM`, 11, fractional bits of the fixed-point format
- `BITWIDTH`, QN+QM+1 (18), signed element width
- `MEMORY_BITWIDTH`, BITWIDTH*NROW, packed vector width
- `IDX_BITWIDTH`, 4, element index width (must hold NROW-1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `dataReady`  in  1  level from dot-product unit; result vector is valid while high
- `inVector`  in  MEMORY_BITWIDTH  packed signed dot-product results; element k at bits [k*BITWIDTH +: BITWIDTH]
- `biasVector`  in  MEMORY_BITWIDTH  packed signed biases, same packing, static during a run
- `outVector`  out  MEMORY_BITWIDTH  packed signed activated results
- `outValid`  out  1  one-cycle pulse: `outVector` complete
- `busy`  out  1  high while a run is in progress
- `overrun`  out  1  sticky: a new `dataReady` rising edge arrived while busy

## Operation
- Reset: state IDLE, `outVector`=0, `outValid`=0, `busy`=0, `overrun`=0, index=0, `dataReady` edge-detect register=0.
- Start condition: rising edge of `dataReady` (current 1, previous sample 0). `dataReady` held high for many cycles starts exactly one run.
- FSM states:
  - IDLE: on start, latch `inVector` into an internal buffer, index←0, go to RUN.
  - RUN: each cycle process element `index`, write it to `outVector` lane `index`, index←index+1. On index==NROW-1, pulse `outValid`, and go to IDLE, or stay in RUN with a fresh capture if a start occurs that same cycle.
- A start while in RUN with index≠NROW-1: ignored, `overrun`←1, and the current run continues on the latched buffer.
- Arithmetic per element:
  - s = in + bias, computed at BITWIDTH+1 bits, then saturated to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1] ([-131072, 131071]).
  - Default, hard sigmoid: y = (s >>> 2) + 2^(QM-1), clamped to [0, 2^QM], i.e. [0, 2048] for 1.0 = 2048.
- Lanes not yet processed in a run keep their previous values. `outVector` is only meaningful on `outValid`.

## Timing
- Start sampled at edge t. Lane k is written at edge t+1+k. `outValid`=1 in the cycle following edge t+NROW, for one cycle.
- Latency from start to complete vector: NROW+1 edges; throughput: one vector per NROW+1 cycles, or one per NROW with a back-to-back start.
- `busy` is high from edge t through the cycle in which `outValid` is high.
- Reset mid-run: all outputs return to reset values at the next edge, the run is abandoned, and no `outValid` is issued.
- `outVector` holds its value after `outValid` until the next run overwrites its lanes.

## Configuration
- `GATE_HARD_TANH_EN`: when defined, the activation is hard tanh, y = clamp(s, -2^QM, 2^QM) = clamp(s, -2048, 2048). When undefined, the activation is the hard sigmoid above. Saturating bias add, FSM and timing are identical in both builds.

## Test plan
- Bias zero, `inVector` all 0, single `dataReady` pulse -> after 17 edges every lane = 1024, exactly one `outValid`.
- Lane0 in=8192, lane1 in=-8192, lane2 in=400, bias 0 -> outputs 2048, 0, 1124 (sigmoid build); with `GATE_HARD_TANH_EN` -> 2048, -2048, 400.
- in=131071 with bias=131071, and in=-131072 with bias=-131072 -> s saturates to 131071 / -131072; sigmoid outputs 2048 / 0; tanh outputs 2048 / -2048.
- `dataReady` held high 16 cycles -> one run only, `outValid` pulses once at edge t+16, `overrun` stays 0. A second rising edge at t+5 -> ignored, `overrun`=1 until reset.
- Back-to-back: second rising edge on the same cycle as lane 15 is written -> new run starts with no idle cycle, `busy` stays high, two `outValid` pulses spaced 16 cycles apart.
- `reset` asserted at edge t+8 -> no `outValid`, `outVector`=0, `busy`=0. A subsequent start completes normally.
